// File: rtl/ysyx_22040386_mem_arbiter.sv
// ysyx_22040386_mem_arbiter
// Two-requester arbiter sharing one single-port RAM between instruction fetch
// and data access. Each access takes two cycles: a grant cycle in IDLE that
// drives the RAM, then a response cycle in GNT_IF/GNT_MEM while the RAM
// returns data.
// Optional feature: define YSYX_22040386_ARB_RR_EN for round-robin arbitration
// between simultaneous requests; otherwise the data port always wins.

module ysyx_22040386_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  arb_clk_i,
    input  logic                  arb_rst_n_i,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_resp_o,
    output logic [31:0]           if_rdata_o,

    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic [DATA_W/8-1:0]   mem_wmask_i,
    output logic                  mem_resp_o,
    output logic [DATA_W-1:0]     mem_rdata_o,

    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    output logic [DATA_W/8-1:0]   ram_wmask_o,
    input  logic [DATA_W-1:0]     ram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Which half of the 64-bit RAM word the granted fetch wants.
    logic if_hi_q;
    logic if_hi_d;

    // Whether the granted data access was a write (write responses carry no data).
    logic mem_we_q;
    logic mem_we_d;

    // Winner of the current arbitration when at least one request is pending.
    logic pick_mem;
    logic any_req;

`ifdef YSYX_22040386_ARB_RR_EN
    // Last-grant pointer: 1 = data port was granted last, 0 = fetch port.
    logic last_mem_q;
    logic last_mem_d;
`endif

    // Byte-offset bits of the fetch address never reach the RAM (word aligned access).
    logic unused_if_addr_bits;
    assign unused_if_addr_bits = &{1'b0, if_addr_i[1:0]};

    assign any_req = if_req_i | mem_req_i;

    // Choose which requester wins when the arbiter is free to grant.
    always_comb begin
`ifdef YSYX_22040386_ARB_RR_EN
        if (if_req_i && mem_req_i) begin
            pick_mem = ~last_mem_q;
        end else begin
            pick_mem = mem_req_i;
        end
`else
        pick_mem = mem_req_i;
`endif
    end

    // Next-state and output decode; responses and grants are suppressed while reset is held.
    always_comb begin
        state_d     = state_q;
        if_hi_d     = if_hi_q;
        mem_we_d    = mem_we_q;
`ifdef YSYX_22040386_ARB_RR_EN
        last_mem_d  = last_mem_q;
`endif
        if_resp_o   = 1'b0;
        if_rdata_o  = '0;
        mem_resp_o  = 1'b0;
        mem_rdata_o = '0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;

        case (state_q)
            IDLE: begin
                if (arb_rst_n_i && any_req) begin
                    ram_en_o = 1'b1;
                    if (pick_mem) begin
                        ram_we_o    = mem_we_i;
                        ram_addr_o  = mem_addr_i;
                        ram_wdata_o = mem_wdata_i;
                        ram_wmask_o = mem_we_i ? mem_wmask_i : '0;
                        mem_we_d    = mem_we_i;
                        state_d     = GNT_MEM;
`ifdef YSYX_22040386_ARB_RR_EN
                        last_mem_d  = 1'b1;
`endif
                    end else begin
                        ram_addr_o  = {if_addr_i[ADDR_W-1:3], 3'b000};
                        if_hi_d     = if_addr_i[2];
                        state_d     = GNT_IF;
`ifdef YSYX_22040386_ARB_RR_EN
                        last_mem_d  = 1'b0;
`endif
                    end
                end
            end

            GNT_IF: begin
                if (arb_rst_n_i) begin
                    if_resp_o  = 1'b1;
                    if_rdata_o = if_hi_q ? ram_rdata_i[63:32] : ram_rdata_i[31:0];
                end
                state_d = IDLE;
            end

            GNT_MEM: begin
                if (arb_rst_n_i) begin
                    mem_resp_o  = 1'b1;
                    mem_rdata_o = mem_we_q ? '0 : ram_rdata_i;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus the per-grant bookkeeping, all cleared by synchronous reset.
    always_ff @(posedge arb_clk_i) begin
        if (!arb_rst_n_i) begin
            state_q    <= IDLE;
            if_hi_q    <= 1'b0;
            mem_we_q   <= 1'b0;
`ifdef YSYX_22040386_ARB_RR_EN
            last_mem_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            if_hi_q    <= if_hi_d;
            mem_we_q   <= mem_we_d;
`ifdef YSYX_22040386_ARB_RR_EN
            last_mem_q <= last_mem_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Directed testbench for ysyx_22040386_mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.

module tb_ysyx_22040386_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_resp;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp;
    logic [63:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wmask;
    logic [63:0] ram_rdata;

    int vecCount  = 0;
    int missCount = 0;

    ysyx_22040386_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .arb_clk_i   (clk),
        .arb_rst_n_i (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_resp_o   (if_resp),
        .if_rdata_o  (if_rdata),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wmask_i (mem_wmask),
        .mem_resp_o  (mem_resp),
        .mem_rdata_o (mem_rdata),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wmask_o (ram_wmask),
        .ram_rdata_i (ram_rdata)
    );

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [63:0] ifAddr,
                                 input logic memReq, input logic memWe,
                                 input logic [63:0] memAddr, input logic [63:0] memWdata,
                                 input logic [7:0] memWmask, input logic [63:0] ramRdata);
        if_req    = ifReq;
        if_addr   = ifAddr;
        mem_req   = memReq;
        mem_we    = memWe;
        mem_addr  = memAddr;
        mem_wdata = memWdata;
        mem_wmask = memWmask;
        ram_rdata = ramRdata;
    endtask

    task automatic idleStimulus();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0);
    endtask

    // One complete fetch: grant, response, then the request is dropped.
    task automatic fetchVector(input logic [63:0] addr, input logic [63:0] rdata,
                               input logic [63:0] expAddr, input logic [31:0] expData);
        nextCycle();
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0);
        @(negedge clk);
        checkOutput("fetch grant ram_en", 64'(ram_en), 64'd1);
        checkOutput("fetch grant ram_we", 64'(ram_we), 64'd0);
        checkOutput("fetch grant ram_addr", ram_addr, expAddr);
        checkOutput("fetch grant ram_wmask", 64'(ram_wmask), 64'd0);
        checkOutput("fetch grant if_resp", 64'(if_resp), 64'd0);
        nextCycle();
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, rdata);
        @(negedge clk);
        checkOutput("fetch resp if_resp", 64'(if_resp), 64'd1);
        checkOutput("fetch resp if_rdata", 64'(if_rdata), 64'(expData));
        checkOutput("fetch resp ram_en", 64'(ram_en), 64'd0);
        checkOutput("fetch resp mem_resp", 64'(mem_resp), 64'd0);
        nextCycle();
        idleStimulus();
        @(negedge clk);
        checkOutput("fetch after if_resp", 64'(if_resp), 64'd0);
        checkOutput("fetch after ram_en", 64'(ram_en), 64'd0);
    endtask

    // One complete data access: grant, response, then the request is dropped.
    task automatic memVector(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wmask, input logic [63:0] rdata,
                             input logic [7:0] expWmask, input logic [63:0] expRdata);
        nextCycle();
        applyStimulus(1'b0, 64'h0, 1'b1, we, addr, wdata, wmask, 64'h0);
        @(negedge clk);
        checkOutput("mem grant ram_en", 64'(ram_en), 64'd1);
        checkOutput("mem grant ram_we", 64'(ram_we), 64'(we));
        checkOutput("mem grant ram_addr", ram_addr, addr);
        checkOutput("mem grant ram_wdata", ram_wdata, wdata);
        checkOutput("mem grant ram_wmask", 64'(ram_wmask), 64'(expWmask));
        checkOutput("mem grant mem_resp", 64'(mem_resp), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 64'h0, 1'b1, we, addr, wdata, wmask, rdata);
        @(negedge clk);
        checkOutput("mem resp mem_resp", 64'(mem_resp), 64'd1);
        checkOutput("mem resp mem_rdata", mem_rdata, expRdata);
        checkOutput("mem resp ram_en", 64'(ram_en), 64'd0);
        checkOutput("mem resp ram_we", 64'(ram_we), 64'd0);
        checkOutput("mem resp if_resp", 64'(if_resp), 64'd0);
        nextCycle();
        idleStimulus();
        @(negedge clk);
        checkOutput("mem after mem_resp", 64'(mem_resp), 64'd0);
        checkOutput("mem after mem_rdata", mem_rdata, 64'd0);
    endtask

    // Main directed sequence.
    initial begin
        logic expMemGrant;
        rst_n = 1'b0;
        idleStimulus();

        // Reset state
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset ram_en", 64'(ram_en), 64'd0);
        checkOutput("reset ram_we", 64'(ram_we), 64'd0);
        checkOutput("reset if_resp", 64'(if_resp), 64'd0);
        checkOutput("reset mem_resp", 64'(mem_resp), 64'd0);
        checkOutput("reset mem_rdata", mem_rdata, 64'd0);
        nextCycle();
        rst_n = 1'b1;

        // Fetches from the upper and lower halves of a RAM word
        fetchVector(64'h0000_0000_8000_0004, 64'h1111_1111_2222_2222, 64'h0000_0000_8000_0000, 32'h1111_1111);
        fetchVector(64'h0000_0000_8000_0010, 64'hAAAA_BBBB_2222_2222, 64'h0000_0000_8000_0010, 32'h2222_2222);

        // Data write, data read (mask forced to 0), and zero-mask write
        memVector(1'b1, 64'h0000_0000_8000_1000, 64'h0000_0000_0000_DEAD, 8'h03,
                  64'h5555_5555_5555_5555, 8'h03, 64'h0);
        memVector(1'b0, 64'h0000_0000_8000_2008, 64'h0000_0000_0000_BEEF, 8'hFF,
                  64'h0123_4567_89AB_CDEF, 8'h00, 64'h0123_4567_89AB_CDEF);
        memVector(1'b1, 64'h0000_0000_8000_2010, 64'hFFFF_0000_FFFF_0000, 8'h00,
                  64'h7777_7777_7777_7777, 8'h00, 64'h0);

        // Both requesters held for 8 cycles, starting from a freshly reset pointer
        nextCycle();
        rst_n = 1'b0;
        idleStimulus();
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            rst_n = 1'b1;
            applyStimulus(1'b1, 64'h0000_0000_8000_0100, 1'b1, 1'b0, 64'h0000_0000_8000_3000,
                          64'h0, 8'h0, 64'(i + 1));
`ifdef YSYX_22040386_ARB_RR_EN
            expMemGrant = ((i / 2) % 2) == 0;
`else
            expMemGrant = 1'b1;
`endif
            @(negedge clk);
            if ((i % 2) == 0) begin
                checkOutput($sformatf("both c%0d ram_en", i), 64'(ram_en), 64'd1);
                checkOutput($sformatf("both c%0d ram_addr", i), ram_addr,
                            expMemGrant ? 64'h0000_0000_8000_3000 : 64'h0000_0000_8000_0100);
                checkOutput($sformatf("both c%0d mem_resp", i), 64'(mem_resp), 64'd0);
                checkOutput($sformatf("both c%0d if_resp", i), 64'(if_resp), 64'd0);
            end else begin
                checkOutput($sformatf("both c%0d ram_en", i), 64'(ram_en), 64'd0);
                checkOutput($sformatf("both c%0d mem_resp", i), 64'(mem_resp), 64'(expMemGrant));
                checkOutput($sformatf("both c%0d if_resp", i), 64'(if_resp), 64'(!expMemGrant));
            end
        end
        nextCycle();
        idleStimulus();

        // Reset asserted during the response cycle of a data read
        nextCycle();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h0000_0000_8000_5000, 64'h0, 8'h0, 64'h0);
        @(negedge clk);
        checkOutput("rstgnt grant ram_en", 64'(ram_en), 64'd1);
        nextCycle();
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h0000_0000_8000_5000, 64'h0, 8'h0, 64'h9999);
        @(negedge clk);
        checkOutput("rstgnt mem_resp", 64'(mem_resp), 64'd0);
        checkOutput("rstgnt ram_en", 64'(ram_en), 64'd0);
        nextCycle();
        idleStimulus();
        @(negedge clk);
        checkOutput("rstgnt next mem_resp", 64'(mem_resp), 64'd0);
        checkOutput("rstgnt next ram_en", 64'(ram_en), 64'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 64'h0000_0000_8000_0200, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0);
        @(negedge clk);
        checkOutput("rstgnt idle grant ram_en", 64'(ram_en), 64'd1);
        checkOutput("rstgnt idle grant ram_addr", ram_addr, 64'h0000_0000_8000_0200);
        nextCycle();
        applyStimulus(1'b1, 64'h0000_0000_8000_0200, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0);
        @(negedge clk);
        checkOutput("rstgnt idle if_resp", 64'(if_resp), 64'd1);

        // Data request pulsed only during a fetch response cycle is never served
        nextCycle();
        idleStimulus();
        nextCycle();
        applyStimulus(1'b1, 64'h0000_0000_8000_0300, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0);
        @(negedge clk);
        checkOutput("pulse grant ram_en", 64'(ram_en), 64'd1);
        nextCycle();
        applyStimulus(1'b1, 64'h0000_0000_8000_0300, 1'b1, 1'b0, 64'h0000_0000_8000_4000,
                      64'h0, 8'h0, 64'h0);
        @(negedge clk);
        checkOutput("pulse gnt_if if_resp", 64'(if_resp), 64'd1);
        checkOutput("pulse gnt_if ram_en", 64'(ram_en), 64'd0);
        checkOutput("pulse gnt_if mem_resp", 64'(mem_resp), 64'd0);
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            idleStimulus();
            @(negedge clk);
            checkOutput($sformatf("pulse after%0d ram_en", i), 64'(ram_en), 64'd0);
            checkOutput($sformatf("pulse after%0d mem_resp", i), 64'(mem_resp), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ysyx_22040386_mem_arbiter.md
YSYX_22040386_MEM_ARBITER -- requirements
Module: ysyx_22040386_mem_arbiter

Interface
REQ-001 SHALL: parameter ADDR_W, 64, address width of all ports.
REQ-002 SHALL: parameter DATA_W, 64, RAM data width (wmask width = DATA_W/8).
REQ-003 SHALL: arb_clk_i  in  1  single clock; all logic on rising edge.
REQ-004 SHALL: arb_rst_n_i  in  1  synchronous, active-low reset.
REQ-005 SHALL: if_req_i  in  1  fetch read request; held with if_addr_i until if_resp_o.
REQ-006 SHALL: if_addr_i  in  ADDR_W  fetch byte address.
REQ-007 SHALL: if_resp_o  out  1  one-cycle pulse; if_rdata_o valid.
REQ-008 SHALL: if_rdata_o  out  32  fetched instruction.
REQ-009 SHALL: mem_req_i  in  1  data request; held with mem_* fields until mem_resp_o.
REQ-010 SHALL: mem_we_i  in  1  1 = write, 0 = read.
REQ-011 SHALL: mem_addr_i / mem_wdata_i / mem_wmask_i  in  ADDR_W / DATA_W / DATA_W/8  data access fields.
REQ-012 SHALL: mem_resp_o  out  1  one-cycle pulse; read data valid or write done.
REQ-013 SHALL: mem_rdata_o  out  DATA_W  load data.
REQ-014 SHALL: ram_en_o / ram_we_o  out  1 / 1  single-port RAM access strobe / write strobe.
REQ-015 SHALL: ram_addr_o / ram_wdata_o / ram_wmask_o  out  ADDR_W / DATA_W / DATA_W/8  RAM access fields.
REQ-016 SHALL: ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after ram_en_o.

Function
REQ-017 SHALL: FSM states IDLE, GNT_IF, GNT_MEM; encoding implementation-defined.
REQ-018 SHALL: IDLE with any request pending -> select winner, drive ram_en_o=1 combinationally that cycle with winner's fields, next state GNT_IF or GNT_MEM.
REQ-019 SHALL: GNT_x -> assert x_resp_o for exactly one cycle, ram_en_o=0, next state IDLE unconditionally.
REQ-020 SHALL: access occupancy 2 cycles; back-to-back requests served at most every 2 cycles; no new grant issued in a GNT_x cycle.
REQ-021 SHALL: fetch grant drives ram_we_o=0, ram_wmask_o=0, ram_addr_o = if_addr_i with bits [2:0] cleared.
REQ-022 SHALL: if_rdata_o = ram_rdata_i[63:32] when latched if_addr_i[2]=1, else [31:0].
REQ-023 SHALL: data grant drives ram_we_o=mem_we_i, ram_wmask_o=mem_wmask_i (0 for reads), ram_wdata_o=mem_wdata_i.
REQ-024 SHALL: mem_rdata_o = ram_rdata_i during mem_resp_o; 0 for writes and outside response cycles.
REQ-025 SHALL: ram_we_o never asserted outside an IDLE-cycle data grant; wmask=0 write still produces mem_resp_o.
REQ-026 SHALL: requester dropping req before its grant is never served; no response generated.
REQ-027 SHALL: a requester may re-assert req in the cycle after its response and is eligible for the next IDLE-cycle grant.

Reset
REQ-028 SHALL: arb_rst_n_i=0 at an edge -> state IDLE, all outputs 0 next cycle, last-grant pointer = IF.
REQ-029 SHALL: reset during GNT_x -> pending response dropped, no x_resp_o pulse.

Configuration
REQ-030 SHALL: macro YSYX_22040386_ARB_RR_EN defined -> round-robin: simultaneous requests granted to requester not granted last; single request always wins.
REQ-031 SHALL: macro undefined -> fixed priority: data port wins every simultaneous request; pointer logic absent.

Verification
REQ-032 SHALL: fetch only, if_addr_i=0x80000004, ram_rdata_i=0x11111111_22222222 -> ram_en_o in cycle 0, if_resp_o cycle 1, if_rdata_o=0x11111111.
REQ-033 SHALL: data write addr=0x80001000, wdata=0xDEAD, wmask=0x03 -> ram_we_o=1, ram_wmask_o=0x03 in grant cycle, mem_resp_o next cycle, mem_rdata_o=0.
REQ-034 SHALL: both requests held 8 cycles, RR_EN defined -> grants MEM, IF, MEM, IF (reset pointer IF); undefined -> MEM every grant, if_resp_o never.
REQ-035 SHALL: reset asserted in GNT_MEM cycle of a read -> mem_resp_o=0, ram_en_o=0, state IDLE next cycle.
REQ-036 SHALL: mem_req_i pulsed 1 cycle while GNT_IF active -> no data grant, no mem_resp_o.
